perceptron_mac_seq: RTL

Sequential, parametrised perceptron neuron for the MLP datapath. It accepts one (input, coefficient) pair per cycle over a valid/ready stream and accumulates N_INPUTS products plus a bias into a wide accumulator. It then applies a selectable activation with shift and saturation, and presents the result on a valid/ready output port. It replaces the fully parallel N-multiplier perceptron with one multiplier, for layers where area matters more than latency.

---
 rtl/perceptron_mac_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/perceptron_mac_seq.sv
// Sequential perceptron neuron: one multiply-accumulate per accepted beat, then a
// registered activation (linear / ReLU / step) with arithmetic shift and saturation.
module perceptron_mac_seq #(
  parameter int N_INPUTS  = 50,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 39,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_coeff,
  input  logic signed [DATA_W-1:0] bias,
  input  logic        [1:0]        act_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_sum,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS + 1) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;

  state_t                      state, state_next;
  logic        [CNT_W-1:0]     cnt;
  logic signed [ACC_W-1:0]     acc;
  logic        [1:0]           mode;
  logic signed [2*DATA_W-1:0]  product;
  logic signed [ACC_W-1:0]     product_ext;
  logic signed [ACC_W-1:0]     bias_ext;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [ACC_W-1:0]     relu_in;
  logic signed [OUT_W-1:0]     act_sum;
  logic                        act_sat;
  logic                        accept;
  logic                        last_beat;

  assign product     = in_data * in_coeff;
  assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
  assign bias_ext    = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign accept      = in_valid & in_ready;
  assign last_beat   = (cnt == CNT_W'(N_INPUTS - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = (N_INPUTS == 1) ? ACT : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_next = ACT;
      end
      ACT: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ReLU clamps the full-precision shifted value before saturation; step looks at raw acc.
  always_comb begin
    shifted = acc >>> OUT_SHIFT;
    relu_in = shifted;
    act_sum = '0;
    act_sat = 1'b0;
    if (mode == 2'd1 && shifted < 0) relu_in = '0;
    if (mode == 2'd2) begin
      act_sum = (acc > 0) ? OUT_W'(1) : '0;
    end else if (relu_in > SAT_MAX) begin
      act_sum = SAT_MAX[OUT_W-1:0];
      act_sat = 1'b1;
    end else if (relu_in < SAT_MIN) begin
      act_sum = SAT_MIN[OUT_W-1:0];
      act_sat = 1'b1;
    end else begin
      act_sum = relu_in[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      mode    <= '0;
      out_sum <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc  <= bias_ext + product_ext;
          cnt  <= CNT_W'(1);
          mode <= act_mode;
        end
        ACC: if (accept) begin
          acc <= acc + product_ext;
          cnt <= cnt + CNT_W'(1);
        end
        ACT: begin
          out_sum <= act_sum;
          out_sat <= act_sat;
        end
        default: ;
      endcase
    end
  end

endmodule
